stream_mux4_1: RTL and testbench

- Per-lane input streamer directly downstream of the 4-bit mux-reset controller; one instance per lane, driven by one bit of that controller's mux_reset bus.
- Captures a block of four WIDTH-bit words in parallel and emits them serially, word 0 first, one per accepted handshake.
- Feeds the systolic matrix-multiply array input edge.

---
 rtl/mm_stream_pkg.sv | 6 +
 rtl/stream_mux4_1_if.sv | 19 +
 rtl/stream_mux4_1.sv | 42 ++++
 tb/tb_stream_mux4_1.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mm_stream_pkg.sv
// mm_stream_pkg: shared word count, select width and streamer state type for the matmul input path.
package mm_stream_pkg;
   localparam int NUM_WORDS = 4;
   localparam int SEL_W = 2;
   typedef enum logic [0:0] {IDLE, STREAM} stream_state_t;
endpackage

// File: rtl/stream_mux4_1_if.sv
// stream_mux4_1_if: block-in / word-out handshake bundle; out_last exists only with STREAM_MUX_LAST_EN.
interface stream_mux4_1_if #(parameter int WIDTH = 16);
   import mm_stream_pkg::*;
   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_WORDS*WIDTH-1:0] in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [WIDTH-1:0]           out_data;
   logic                       busy;
`ifdef STREAM_MUX_LAST_EN
   logic                       out_last;
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy, out_last);
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy, out_last);
`else
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/stream_mux4_1.sv
// stream_mux4_1: captures a 4-word block and streams it word 0 first; optional out_last via STREAM_MUX_LAST_EN.
module stream_mux4_1 import mm_stream_pkg::*; #(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mux_en,
   stream_mux4_1_if.slave s
);
   logic [NUM_WORDS-1:0][WIDTH-1:0] words_q, words_d;
   logic [SEL_W-1:0]                sel_q, sel_d;
   stream_state_t                   state_q, state_d;
   logic                            last, acc, rdy, cap;
   // rdy excludes rst_n so the reset net only gates the port, never a flop input
   always_comb begin
      last    = sel_q == SEL_W'(NUM_WORDS - 1);
      acc     = mux_en && state_q == STREAM && s.out_ready;
      rdy     = mux_en && (state_q == IDLE || (last && s.out_ready));
      cap     = s.in_valid && rdy;
      state_d = !mux_en ? IDLE : cap ? STREAM : (acc && last) ? IDLE : state_q;
      sel_d   = (!mux_en || cap) ? '0 : acc ? sel_q + 1'b1 : sel_q;
      words_d = !mux_en ? '0 : cap ? s.in_data : words_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         words_q <= words_d;
      end
   end
   assign s.in_ready  = rst_n && rdy;
   assign s.out_valid = state_q == STREAM;
   assign s.busy      = state_q == STREAM;
   assign s.out_data  = words_q[sel_q];
`ifdef STREAM_MUX_LAST_EN
   assign s.out_last  = state_q == STREAM && last;
`endif
endmodule

// File: tb/tb_stream_mux4_1.sv
// tb_stream_mux4_1: directed stimulus, queue-based reference model checked every negedge, plus literal checks.
module tb_stream_mux4_1;
   logic clk = 1'b0;
   logic rst_n;
   logic mux_en;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] q[$];
   logic [63:0] b1 = 64'h0004_0003_0002_0001;
   logic [63:0] b2 = 64'h00D0_00C0_00B0_00A0;
   logic [63:0] b3 = 64'h0444_0333_0222_0111;
   logic [15:0] b2b[8] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0};

   always #5 clk = ~clk;

   stream_mux4_1_if #(.WIDTH(16)) sif ();
   stream_mux4_1 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .mux_en(mux_en), .s(sif.slave));

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference: the outstanding words as a queue; head is what must be on out_data.
   always @(posedge clk or negedge rst_n) begin
      logic take;
      if (!rst_n || !mux_en) q.delete();
      else begin
         take = q.size() == 0 || (q.size() == 1 && sif.out_ready);
         if (q.size() != 0 && sif.out_ready) void'(q.pop_front());
         if (sif.in_valid && take)
            for (int k = 0; k < 4; k++) q.push_back(sif.in_data[k*16 +: 16]);
      end
   end

   always @(negedge clk) begin
      chk("m_in_ready", {31'd0, sif.in_ready},
          {31'd0, rst_n && mux_en && (q.size() == 0 || (q.size() == 1 && sif.out_ready))});
      chk("m_out_valid", {31'd0, sif.out_valid}, {31'd0, q.size() != 0});
      chk("m_busy", {31'd0, sif.busy}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("m_out_data", {16'd0, sif.out_data}, {16'd0, q[0]});
`ifdef STREAM_MUX_LAST_EN
      chk("m_out_last", {31'd0, sif.out_last}, {31'd0, q.size() == 1});
`endif
   end

   initial begin
      rst_n = 1'b0;
      mux_en = 1'b1;
      sif.in_valid = 1'b1;
      sif.in_data = b3;
      sif.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, sif.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, sif.out_data}, 32'd0);
      step();
      step();
      mux_en = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      chk("dis_in_ready", {31'd0, sif.in_ready}, 32'd0);
      chk("dis_out_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("dis_busy", {31'd0, sif.busy}, 32'd0);
      // single block
      mux_en = 1'b1;
      sif.in_data = b1;
      #1;
      chk("idle_in_ready", {31'd0, sif.in_ready}, 32'd1);
      step();
      sif.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("single_data", {16'd0, sif.out_data}, k + 1);
         chk("single_valid", {31'd0, sif.out_valid}, 32'd1);
         step();
      end
      chk("single_end_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("single_end_busy", {31'd0, sif.busy}, 32'd0);
      // back-to-back blocks
      sif.in_valid = 1'b1;
      sif.in_data = b1;
      step();
      sif.in_data = b2;
      for (int k = 0; k < 8; k++) begin
         chk("b2b_data", {16'd0, sif.out_data}, {16'd0, b2b[k]});
         chk("b2b_valid", {31'd0, sif.out_valid}, 32'd1);
         if (k == 3) chk("b2b_in_ready", {31'd0, sif.in_ready}, 32'd1);
         step();
         if (k == 3) sif.in_valid = 1'b0;
      end
      chk("b2b_end_valid", {31'd0, sif.out_valid}, 32'd0);
      // backpressure on word 1
      sif.in_valid = 1'b1;
      sif.in_data = b1;
      step();
      sif.in_valid = 1'b0;
      chk("bp_w0", {16'd0, sif.out_data}, 32'h0001);
      step();
      sif.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold_data", {16'd0, sif.out_data}, 32'h0002);
         chk("bp_hold_valid", {31'd0, sif.out_valid}, 32'd1);
      end
      sif.out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         chk("bp_resume", {16'd0, sif.out_data}, k + 1);
         step();
      end
      chk("bp_end_valid", {31'd0, sif.out_valid}, 32'd0);
      // mid-stream disable
      sif.in_valid = 1'b1;
      sif.in_data = b2;
      step();
      sif.in_valid = 1'b0;
      chk("md_w0", {16'd0, sif.out_data}, 32'h00A0);
      step();
      chk("md_w1", {16'd0, sif.out_data}, 32'h00B0);
      step();
      mux_en = 1'b0;
      step();
      chk("md_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("md_busy", {31'd0, sif.busy}, 32'd0);
      mux_en = 1'b1;
      sif.in_valid = 1'b1;
      sif.in_data = b3;
      step();
      sif.in_valid = 1'b0;
      chk("md_restart", {16'd0, sif.out_data}, 32'h0111);
      repeat (4) step();
      // async reset mid-stream at sel=2
      sif.in_valid = 1'b1;
      sif.in_data = b1;
      step();
      sif.in_valid = 1'b0;
      step();
      step();
      chk("ar_w2", {16'd0, sif.out_data}, 32'h0003);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("ar_data", {16'd0, sif.out_data}, 32'd0);
      chk("ar_busy", {31'd0, sif.busy}, 32'd0);
      chk("ar_in_ready", {31'd0, sif.in_ready}, 32'd0);
`ifdef STREAM_MUX_LAST_EN
      chk("ar_last", {31'd0, sif.out_last}, 32'd0);
`endif
      step();
      rst_n = 1'b1;
      sif.in_valid = 1'b1;
      sif.in_data = b2;
      step();
      sif.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("post_data", {16'd0, sif.out_data}, {16'd0, b2b[k+4]});
`ifdef STREAM_MUX_LAST_EN
         chk("post_last", {31'd0, sif.out_last}, {31'd0, k == 3});
`endif
         step();
      end
      chk("post_end_valid", {31'd0, sif.out_valid}, 32'd0);
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
